// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arb_pkg
//  Description : Shared types and constants for the two-port data-memory
//                arbiter (state encoding, master index, dm access codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Master index: 0 = CPU load/store path, 1 = DMA/debug loader
    typedef logic master_idx_t;

    localparam master_idx_t MASTER0 = 1'b0;
    localparam master_idx_t MASTER1 = 1'b1;

    // Access width/sign codes, identical to the dm.DMType encoding
    localparam logic [2:0] DMTYPE_WORD       = 3'd0;
    localparam logic [2:0] DMTYPE_HALFWORD   = 3'd1;
    localparam logic [2:0] DMTYPE_HALFWORD_U = 3'd2;
    localparam logic [2:0] DMTYPE_BYTE       = 3'd3;
    localparam logic [2:0] DMTYPE_BYTE_U     = 3'd4;

    // Default cap on consecutive locked beats for one master
    localparam int DEFAULT_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/dm_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arb_pick
//  Description : Combinational winner select between the two masters.
//                DM_ARB_RR_EN defined   : round-robin, the master that did
//                                         not own the last transfer wins ties.
//                DM_ARB_RR_EN undefined : fixed priority, master 0 wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic [1:0]  req,
`ifdef DM_ARB_RR_EN
    input  master_idx_t last_owner,
`endif
    output logic        any_req,
    output master_idx_t winner
);

    // Pick the winner; only the tie case depends on the arbitration policy
    always_comb begin
        any_req = |req;
        winner  = MASTER0;
        if (req == 2'b10) begin
            winner = MASTER1;
        end
`ifdef DM_ARB_RR_EN
        else if (req == 2'b11) begin
            winner = (last_owner == MASTER0) ? MASTER1 : MASTER0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-port arbiter sharing the data memory between the CPU
//                load/store path (m0) and a DMA/debug loader (m1). Per-beat
//                valid/ready arbitration, locked bursts capped at MAX_BURST
//                beats, registered read data returned to the owning master.
//                Optional feature macro: DM_ARB_RR_EN (round-robin ties).
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_dmtype,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_dmtype,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_dmtype,
    input  logic [31:0] dm_dout,
    output logic        busy
);

    // Last beat index of a locked burst (beat_cnt counts from 0)
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic [3:0]  beat_cnt;
    logic [3:0]  beat_cnt_nxt;
    logic        xfer0;
    logic        xfer1;
    logic        cur_req;
    logic        cur_lock;
    logic        any_req;
    master_idx_t winner;
    arb_state_t  win_state;

    // Grants come straight from the state register, so they are registered
    // and drop as soon as the asynchronous reset hits.
    assign m0_gnt = (state == GNT0);
    assign m1_gnt = (state == GNT1);
    assign busy   = (state != IDLE);
    assign xfer0  = m0_gnt & m0_req;
    assign xfer1  = m1_gnt & m1_req;

`ifdef DM_ARB_RR_EN
    master_idx_t last_owner;
    master_idx_t pick_last;

    // While a master is transferring, it is the owner the tie-break must see
    always_comb begin
        pick_last = last_owner;
        if (state == GNT0) begin
            pick_last = MASTER0;
        end else if (state == GNT1) begin
            pick_last = MASTER1;
        end
    end

    // Remember who made the most recent transfer; m0 wins the first tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner <= MASTER1;
        end else if (xfer0) begin
            last_owner <= MASTER0;
        end else if (xfer1) begin
            last_owner <= MASTER1;
        end
    end

    dm_arb_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (pick_last),
        .any_req    (any_req),
        .winner     (winner)
    );
`else
    dm_arb_pick u_pick (
        .req        ({m1_req, m0_req}),
        .any_req    (any_req),
        .winner     (winner)
    );
`endif

    assign win_state = (winner == MASTER1) ? GNT1 : GNT0;

    // Ownership state and burst beat counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state: arbitrate from idle, hold under lock, release otherwise
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        cur_req      = 1'b0;
        cur_lock     = 1'b0;
        if (state == GNT0) begin
            cur_req  = m0_req;
            cur_lock = m0_lock;
        end else if (state == GNT1) begin
            cur_req  = m1_req;
            cur_lock = m1_lock;
        end
        case (state)
            IDLE: begin
                beat_cnt_nxt = 4'd0;
                state_nxt    = any_req ? win_state : IDLE;
            end
            GNT0, GNT1: begin
                if (!cur_req) begin
                    // owner walked away without a beat
                    state_nxt    = IDLE;
                    beat_cnt_nxt = 4'd0;
                end else if (cur_lock && (beat_cnt < BURST_LAST)) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end else begin
                    state_nxt    = any_req ? win_state : IDLE;
                    beat_cnt_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Route the owning master to dm; idle drives all zeros
    always_comb begin
        dm_we     = 1'b0;
        dm_addr   = 32'd0;
        dm_din    = 32'd0;
        dm_dmtype = 3'd0;
        if (state == GNT0) begin
            dm_we     = m0_req & m0_we;
            dm_addr   = m0_addr;
            dm_din    = m0_wdata;
            dm_dmtype = m0_dmtype;
        end else if (state == GNT1) begin
            dm_we     = m1_req & m1_we;
            dm_addr   = m1_addr;
            dm_din    = m1_wdata;
            dm_dmtype = m1_dmtype;
        end
    end

    // Capture load data on a load transfer; rdata holds until the next load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_rvalid <= xfer0 & ~m0_we;
            m1_rvalid <= xfer1 & ~m1_we;
            if (xfer0 && !m0_we) begin
                m0_rdata <= dm_dout;
            end
            if (xfer1 && !m1_we) begin
                m1_rdata <= dm_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Self-checking bench for dm_arbiter. A transaction-level
//                model (owner / beats-in-burst / word memory) predicts every
//                output each cycle; directed phases pin key literal values,
//                then a randomized phase exercises mixed traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic [2:0]  m0_dmtype = 3'd0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic [2:0]  m1_dmtype = 3'd0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_we, busy;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [2:0]  dm_dmtype;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment memory standing in for dm (word granularity)
    logic [31:0] env_mem [0:255];
    assign dm_dout = env_mem[dm_addr[9:2]];

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          owner = -1;     // -1 none, else master index
    int          beats = 0;      // beats completed in the current burst
    int          last  = 1;      // master of the most recent transfer
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          xfer_next [2];  // req&gnt seen before the coming edge

    dm_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_dmtype(m0_dmtype), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_dmtype(m1_dmtype), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dmtype(dm_dmtype),
        .dm_dout(dm_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic req_of(input int k);
        return (k == 0) ? m0_req : m1_req;
    endfunction

    // Winner among current requests, or -1 when nobody asks
    function automatic int choose();
        if (m0_req && m1_req) begin
`ifdef DM_ARB_RR_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; beats = 0; last = 1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    endtask

    // Advance the model by one clock edge using the pre-edge inputs
    task automatic model_step();
        int t;
        t = -1;
        if (owner == 0 && m0_req) t = 0;
        if (owner == 1 && m1_req) t = 1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (t == 0) begin
            if (!m0_we) begin exp_rv[0] = 1'b1; exp_rd[0] = ref_mem[m0_addr[9:2]]; end
            else ref_mem[m0_addr[9:2]] = m0_wdata;
        end
        if (t == 1) begin
            if (!m1_we) begin exp_rv[1] = 1'b1; exp_rd[1] = ref_mem[m1_addr[9:2]]; end
            else ref_mem[m1_addr[9:2]] = m1_wdata;
        end
        if (owner == -1) begin
            owner = choose(); beats = 0;
        end else if (t == -1) begin
            owner = -1; beats = 0;
        end else begin
            beats++;
            last = t;
            if (!(((t == 0) ? m0_lock : m1_lock) && beats < MB)) begin
                owner = choose(); beats = 0;
            end
        end
    endtask

    task automatic compare();
        logic        e_we;
        logic [31:0] e_addr, e_din;
        logic [2:0]  e_dt;
        e_we = 1'b0; e_addr = 32'd0; e_din = 32'd0; e_dt = 3'd0;
        if (owner == 0) begin e_we = m0_req & m0_we; e_addr = m0_addr; e_din = m0_wdata; e_dt = m0_dmtype; end
        if (owner == 1) begin e_we = m1_req & m1_we; e_addr = m1_addr; e_din = m1_wdata; e_dt = m1_dmtype; end
        chk("m0_gnt", m0_gnt, owner == 0);
        chk("m1_gnt", m1_gnt, owner == 1);
        chk("busy", busy, owner != -1);
        chk("m0_rvalid", m0_rvalid, exp_rv[0]);
        chk("m1_rvalid", m1_rvalid, exp_rv[1]);
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        chk("dm_we", dm_we, e_we);
        chk("dm_addr", dm_addr, e_addr);
        chk("dm_din", dm_din, e_din);
        chk("dm_dmtype", dm_dmtype, e_dt);
    endtask

    // Environment dm: commit stores at the rising edge
    initial forever begin
        @(posedge clk);
        if (dm_we) env_mem[dm_addr[9:2]] = dm_din;
    end

    // Model step at each edge, then compare after the stimulus has settled
    initial forever begin
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step();
        #2;
        compare();
        xfer_next[0] = m0_req & m0_gnt;
        xfer_next[1] = m1_req & m1_gnt;
    end

    task automatic drv(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic l);
        if (k == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_lock = l;
            m0_dmtype = 3'($urandom_range(0, 4));
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_lock = l;
            m1_dmtype = 3'($urandom_range(0, 4));
        end
    endtask

    task automatic wait_xfer(input int k, input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            if (xfer_next[k]) done = 1'b1;
        end
        chk(nm, done, 1'b1);
    endtask

    // Release both masters as soon as each is allowed to change
    task automatic drain();
        for (int c = 0; c < 60 && (m0_req || m1_req); c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                if (xfer_next[k] || !req_of(k)) drv(k, 0, 0, 32'd0, 32'd0, 0);
        end
        chk("drain_done", {m1_req, m0_req}, 2'b00);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [8];
        int n, i1, m1_before;
        bit m0_done;

        for (int i = 0; i < 256; i++) begin
            env_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        env_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        model_reset();

        // Reset with both requests pending
        drv(0, 1, 0, 32'h100, 32'd0, 0);
        drv(1, 1, 0, 32'h104, 32'd0, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_m1_gnt", m1_gnt, 1'b0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #3;
        chk("post_rst_m0_gnt", m0_gnt, 1'b1);
        chk("post_rst_m1_gnt", m1_gnt, 1'b0);
        wait_xfer(0, "rst_m0_xfer");
        drv(0, 0, 0, 32'd0, 32'd0, 0);
        wait_xfer(1, "rst_m1_xfer");
        drv(1, 0, 0, 32'd0, 32'd0, 0);
        repeat (3) @(posedge clk);

        // Single load latency
        @(posedge clk); #1;
        drv(0, 1, 0, 32'h10, 32'd0, 0);
        @(posedge clk); #3;
        chk("load_gnt_n1", m0_gnt, 1'b1);
        chk("load_rvalid_n1", m0_rvalid, 1'b0);
        @(posedge clk); #1;
        drv(0, 0, 0, 32'd0, 32'd0, 0);
        #2;
        chk("load_rvalid_n2", m0_rvalid, 1'b1);
        chk("load_rdata", m0_rdata, 32'hDEADBEEF);
        @(posedge clk); #3;
        chk("load_rvalid_n3", m0_rvalid, 1'b0);
        chk("load_rdata_hold", m0_rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk);

        // Contention: continuous unlocked stores from both masters
        @(posedge clk); #1;
        drv(0, 1, 1, 32'h200, $urandom, 0);
        drv(1, 1, 1, 32'h280, $urandom, 0);
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                if (xfer_next[k]) begin
                    if (n < 8) seq[n] = k;
                    n++;
                    drv(k, 1, 1, 32'h200 + 32'(128 * k) + 32'(4 * (n % 16)), $urandom, 0);
                end
        end
        chk("contention_count", n >= 8, 1'b1);
        for (int i = 1; i < 8; i++) begin
`ifdef DM_ARB_RR_EN
            chk("rr_alternate", seq[i], 1 - seq[i-1]);
`else
            chk("fixed_m0_wins", seq[i], 0);
`endif
        end
        drain();

        // Locked burst from m1 while m0 waits
        @(posedge clk); #1;
        i1 = 0; m1_before = 0; m0_done = 1'b0;
        drv(1, 1, 1, 32'h20, 32'h1000_0000, 1);
        @(posedge clk); #1;
        drv(0, 1, 0, 32'h300, 32'd0, 0);
        for (int c = 0; c < 60 && !(i1 == 6 && m0_done); c++) begin
            @(posedge clk); #1;
            if (xfer_next[1]) begin
                i1++;
                if (!m0_done) m1_before++;
                if (i1 < 6) drv(1, 1, 1, 32'h20 + 32'(4 * i1), 32'h1000_0000 + 32'(i1), 1);
                else drv(1, 0, 0, 32'd0, 32'd0, 0);
            end
            if (xfer_next[0]) begin
                m0_done = 1'b1;
                drv(0, 0, 0, 32'd0, 32'd0, 0);
            end
        end
        chk("burst_done", (i1 == 6) && m0_done, 1'b1);
        chk("burst_m1_beats", m1_before, 4);
        for (int i = 0; i < 6; i++)
            chk("burst_mem", env_mem[8 + i], 32'h1000_0000 + 32'(i));
        drain();

        // Abandon: m0 drops req while granted, before any transfer
        @(posedge clk); #1;
        drv(0, 1, 1, 32'h44, 32'h5555_5555, 0);
        @(posedge clk); #3;
        chk("abandon_gnt", m0_gnt, 1'b1);
        drv(0, 0, 1, 32'h44, 32'h5555_5555, 0);
        #1;
        chk("abandon_no_we", dm_we, 1'b0);
        @(posedge clk); #3;
        chk("abandon_idle_busy", busy, 1'b0);
        chk("abandon_idle_gnt", m0_gnt, 1'b0);
        chk("abandon_mem", env_mem[17], init_val(17));
        repeat (2) @(posedge clk);

        // Reset pulsed during an m1 store grant
        @(posedge clk); #1;
        drv(1, 1, 1, 32'h40, 32'hCAFE_F00D, 0);
        @(posedge clk); #3;
        chk("midrst_gnt", m1_gnt, 1'b1);
        chk("midrst_we_before", dm_we, 1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_we_drop", dm_we, 1'b0);
        chk("midrst_gnt_drop", m1_gnt, 1'b0);
        drv(1, 0, 0, 32'd0, 32'd0, 0);
        @(posedge clk); #3;
        chk("midrst_mem", env_mem[16], init_val(16));
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Randomized mixed traffic
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                if (xfer_next[k] || !req_of(k)) begin
                    if ($urandom_range(0, 9) < 7)
                        drv(k, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                            $urandom, 1'($urandom_range(0, 1)));
                    else
                        drv(k, 0, 0, 32'd0, 32'd0, 0);
                end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
